// File: rtl/mem_filler.sv
// mem_filler: walks BASE..BASE+LEN-1 issuing one wr/ack handshaked write per word.
//   clk_sys, reset     : system clock, async active-high reset
//   i_ena              : clock enable gating the start of each write
//   i_trigger          : run starts on a rising edge
//   i_mode, i_pattern  : fill mode and value/seed, latched at start
//   i_abort            : synchronous cancel of a run
//   i_ack              : memory accepted the current write
//   o_busy             : run in progress
//   o_wr, o_addr, o_data : registered write strobe, address and data
//   o_done             : one-cycle pulse on normal completion
module mem_filler #(
  parameter int                ADDR_W  = 25,
  parameter int                DATA_W  = 8,
  parameter logic [ADDR_W-1:0] BASE    = '0,
  parameter logic [31:0]       LEN     = 32'h20000,
  parameter int                BLK_LOG = 7
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              i_ena,
  input  logic              i_trigger,
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_pattern,
  input  logic              i_abort,
  input  logic              i_ack,
  output logic              o_busy,
  output logic              o_wr,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_done
);
  typedef enum logic [1:0] {IDLE, NEXT, WRITE, DONE} state_t;
  state_t              r_state;
  logic                r_trig_d;
  logic [1:0]          r_mode;
  logic [DATA_W-1:0]   r_pat;
  logic [31:0]         r_cnt;
  logic [15:0]         r_lfsr;
  logic                r_busy, r_wr, r_done;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                w_start;
  logic [15:0]         w_seed, w_lfsr_nx;
  logic [DATA_W-1:0]   w_fill;
  assign w_start   = i_trigger & ~r_trig_d;
  // an all-zero seed would lock the LFSR, so substitute a fixed nonzero one
  assign w_seed    = (i_pattern == '0) ? 16'hACE1 : 16'(i_pattern);
  assign w_lfsr_nx = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  always_comb
    w_fill = (r_mode == 2'd0) ? r_pat :
             (r_mode == 2'd1) ? (r_cnt[BLK_LOG] ? ~r_pat : r_pat) :
             (r_mode == 2'd2) ? r_cnt[DATA_W-1:0] : r_lfsr[DATA_W-1:0];
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_trig_d <= 1'b1;
      r_mode   <= '0;
      r_pat    <= '0;
      r_cnt    <= '0;
      r_lfsr   <= '0;
      r_busy   <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_trig_d <= i_trigger;
      r_done   <= 1'b0;
      case (r_state)
        IDLE:
          if (w_start && !i_abort) begin
            r_mode  <= i_mode;
            r_pat   <= i_pattern;
            r_cnt   <= '0;
            r_lfsr  <= w_seed;
            r_busy  <= 1'b1;
            r_state <= NEXT;
          end
        NEXT:
          if (i_abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (i_ena) begin
            r_addr  <= BASE + r_cnt[ADDR_W-1:0];
            r_data  <= w_fill;
            r_wr    <= 1'b1;
            r_state <= WRITE;
          end
        WRITE:
          // abort wins over a coincident ack so the aborted word is not counted
          if (i_abort) begin
            r_wr    <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (i_ack) begin
            r_wr   <= 1'b0;
            r_lfsr <= w_lfsr_nx;
            if (r_cnt == LEN - 32'd1) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_cnt   <= r_cnt + 32'd1;
              r_state <= NEXT;
            end
          end
        DONE:
          r_state <= IDLE;
        default:
          r_state <= IDLE;
      endcase
    end
  end
  assign o_busy = r_busy;
  assign o_wr   = r_wr;
  assign o_addr = r_addr;
  assign o_data = r_data;
  assign o_done = r_done;
endmodule

// File: tb/tb_mem_filler.sv
// tb_mem_filler: directed checks of mem_filler over four parameterisations sharing stimulus
module tb_mem_filler;
  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  always #5 clk_sys = ~clk_sys;
  logic        ena = 1'b1, trigger = 1'b1, abort = 1'b0, gate = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  pattern = 8'd0;
  int          lat = 0;
  logic [3:0]  busy, wr, done, ack;
  logic [24:0] addr4 [4];
  logic [3:0]  a3;
  logic [7:0]  data [4];
  int          wcnt [4];
  int          n_chk = 0, n_pass = 0;
  int          cyc = 0, sel = 0, t0 = 0;
  int          nrise, bad_ena, bad_gap, unstable, ndone, bad_done, rise0, prise, done_cyc;
  logic        pwr, pena, pdone;
  logic [24:0] pa;
  logic [7:0]  pd;
  logic [24:0] qa [$];
  logic [7:0]  qd [$];
  logic [7:0]  exp_alt [6] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
  logic [3:0]  exp_wrap [4] = '{4'hE, 4'hF, 4'h0, 4'h1};
  assign addr4[3] = {21'b0, a3};
  for (genvar g = 0; g < 4; g++) begin : g_ack
    assign ack[g] = wr[g] && (wcnt[g] >= lat);
    always @(posedge clk_sys) wcnt[g] <= (wr[g] && !ack[g]) ? wcnt[g] + 1 : 0;
  end
  mem_filler #(.BASE(25'h10000), .LEN(32'd4)) u0 (
    .clk_sys(clk_sys), .reset(reset), .i_ena(ena), .i_trigger(trigger), .i_mode(mode),
    .i_pattern(pattern), .i_abort(abort), .i_ack(ack[0]), .o_busy(busy[0]), .o_wr(wr[0]),
    .o_addr(addr4[0]), .o_data(data[0]), .o_done(done[0]));
  mem_filler #(.LEN(32'd6), .BLK_LOG(1)) u1 (
    .clk_sys(clk_sys), .reset(reset), .i_ena(ena), .i_trigger(trigger), .i_mode(mode),
    .i_pattern(pattern), .i_abort(abort), .i_ack(ack[1]), .o_busy(busy[1]), .o_wr(wr[1]),
    .o_addr(addr4[1]), .o_data(data[1]), .o_done(done[1]));
  mem_filler #(.LEN(32'd8)) u2 (
    .clk_sys(clk_sys), .reset(reset), .i_ena(ena), .i_trigger(trigger), .i_mode(mode),
    .i_pattern(pattern), .i_abort(abort), .i_ack(ack[2]), .o_busy(busy[2]), .o_wr(wr[2]),
    .o_addr(addr4[2]), .o_data(data[2]), .o_done(done[2]));
  mem_filler #(.ADDR_W(4), .BASE(4'hE), .LEN(32'd4)) u3 (
    .clk_sys(clk_sys), .reset(reset), .i_ena(ena), .i_trigger(trigger), .i_mode(mode),
    .i_pattern(pattern), .i_abort(abort), .i_ack(ack[3]), .o_busy(busy[3]), .o_wr(wr[3]),
    .o_addr(a3), .o_data(data[3]), .o_done(done[3]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    logic [24:0] a;
    @(negedge clk_sys);
    a = addr4[sel];
    if (wr[sel] && !pwr) begin
      nrise++;
      if (!pena) bad_ena++;
      if (nrise == 1) rise0 = cyc;
      else if (cyc - prise != 2) bad_gap++;
      prise = cyc;
    end
    if (wr[sel] && pwr && (a != pa || data[sel] != pd)) unstable++;
    if (wr[sel] && ack[sel]) begin
      qa.push_back(a);
      qd.push_back(data[sel]);
    end
    if (done[sel]) begin
      ndone++;
      done_cyc = cyc;
      if (busy[sel] || pdone) bad_done++;
    end
    pwr = wr[sel];
    pena = ena;
    pa = a;
    pd = data[sel];
    pdone = done[sel];
    @(posedge clk_sys);
    #1;
    cyc++;
    if (gate) ena = (cyc % 4 == 0);
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic clr();
    nrise = 0; bad_ena = 0; bad_gap = 0; unstable = 0; ndone = 0; bad_done = 0;
    rise0 = 0; prise = 0; done_cyc = 0; pwr = 1'b0; pena = 1'b0; pdone = 1'b0;
    pa = '0; pd = '0;
    qa.delete();
    qd.delete();
  endtask
  task automatic start_run(input int s);
    sel = s;
    trigger = 1'b0;
    tick();
    clr();
    trigger = 1'b1;
    t0 = cyc;
  endtask
  initial begin
    clr();
    run(3);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wr", 32'(wr), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_addr", addr4[0], 32'h0);
    reset = 1'b0;
    run(6);
    chk("held_trig_no_run", 32'(busy | wr), 32'h0);
    mode = 2'd0; pattern = 8'hA5; lat = 0;
    start_run(0);
    tick();
    chk("c_busy_t1", 32'(busy[0]), 32'h1);
    chk("c_wr_t1", 32'(wr[0]), 32'h0);
    tick();
    chk("c_wr_t2", 32'(wr[0]), 32'h1);
    run(20);
    chk("c_nwr", nrise, 4);
    chk("c_first_wr", rise0 - t0, 2);
    chk("c_gap", bad_gap, 0);
    chk("c_ndone", ndone, 1);
    chk("c_done_cyc", done_cyc - t0, 9);
    chk("c_done_busy", bad_done, 0);
    chk("c_nwrites", qa.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("c_addr%0d", i), qa[i], 32'h10000 + i);
      chk($sformatf("c_data%0d", i), qd[i], 32'hA5);
    end
    mode = 2'd1; pattern = 8'h00; gate = 1'b1;
    start_run(1);
    run(80);
    gate = 1'b0;
    ena = 1'b1;
    chk("alt_nwr", nrise, 6);
    chk("alt_ena", bad_ena, 0);
    chk("alt_ndone", ndone, 1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("alt_addr%0d", i), qa[i], i);
      chk($sformatf("alt_data%0d", i), qd[i], exp_alt[i]);
    end
    mode = 2'd3; pattern = 8'h00; lat = 3;
    start_run(0);
    run(60);
    chk("lfsr_nwrites", qa.size(), 4);
    chk("lfsr_d0", qd[0], 32'hE1);
    chk("lfsr_d1", qd[1], 32'hC3);
    chk("lfsr_d2", qd[2], 32'h87);
    chk("lfsr_stable", unstable, 0);
    chk("lfsr_done_cyc", done_cyc - t0, 21);
    lat = 0;
    mode = 2'd2;
    start_run(2);
    run(6);
    chk("ab_wr_pre", 32'(wr[2]), 32'h1);
    chk("ab_addr_pre", addr4[2], 32'h2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_wr", 32'(wr[2]), 32'h0);
    chk("ab_busy", 32'(busy[2]), 32'h0);
    run(10);
    chk("ab_ndone", ndone, 0);
    chk("ab_idle", 32'(busy[2]), 32'h0);
    start_run(2);
    run(25);
    chk("ab_re_n", qa.size(), 8);
    chk("ab_re_addr0", qa[0], 32'h0);
    chk("ab_re_data7", qd[7], 32'h7);
    chk("ab_re_done", ndone, 1);
    mode = 2'd0; pattern = 8'h3C;
    start_run(0);
    run(4);
    chk("rm_wr_pre", 32'(wr[0]), 32'h1);
    reset = 1'b1;
    #1;
    chk("rm_busy", 32'(busy[0]), 32'h0);
    chk("rm_wr", 32'(wr[0]), 32'h0);
    chk("rm_addr", addr4[0], 32'h0);
    chk("rm_data", 32'(data[0]), 32'h0);
    run(2);
    reset = 1'b0;
    clr();
    run(10);
    chk("rm_no_restart", 32'(busy | wr), 32'h0);
    chk("rm_no_done", ndone, 0);
    start_run(0);
    run(3);
    trigger = 1'b0;
    tick();
    trigger = 1'b1;
    run(20);
    chk("rt_nwr", nrise, 4);
    chk("rt_nwrites", qa.size(), 4);
    chk("rt_ndone", ndone, 1);
    mode = 2'd2;
    start_run(3);
    run(20);
    chk("wrap_n", qa.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wrap_addr%0d", i), qa[i], 32'(exp_wrap[i]));
      chk($sformatf("wrap_data%0d", i), qd[i], i);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
